// File: rtl/stream_demux4_if.sv
// stream_demux4_if: bundle of the producer-side and consumer-side signals of
// the 1-to-4 stream demultiplexer.
//   in_data/in_sel/in_valid/in_ready/rr_en : single input stream and routing
//   out_data/out_valid/out_ready           : four output channels, packed
//                                            channel n at [n*DW +: DW]
//   rr_ptr/xfer_cnt                        : status (round-robin pointer,
//                                            accepted-transfer count)
// Modports:
//   master : the environment (producer + consumers) driving the block
//   slave  : the demultiplexer itself
interface stream_demux4_if #(
    parameter int DW = 4
);
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic            rr_en;
    logic [4*DW-1:0] out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [1:0]      rr_ptr;
    logic [7:0]      xfer_cnt;

    modport master (
        output in_data, in_sel, in_valid, rr_en, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, xfer_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, rr_en, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, xfer_cnt
    );
endinterface

// File: rtl/stream_demux4.sv
// stream_demux4: registered 1-to-4 demultiplexer with valid/ready handshake.
// Each accepted input word is routed to one of four one-entry output
// registers, selected by in_sel or by an internal round-robin pointer when
// rr_en=1. A channel can take a new word in the same cycle its old word is
// drained, so a continuously ready consumer sees no bubbles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears channels, pointer, count)
//   bus   : stream_demux4_if slave modport (input stream, four output
//           channels, rr_ptr and xfer_cnt status)
module stream_demux4 #(
    parameter int DW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_demux4_if.slave bus
);
    logic [DW-1:0] data_q [4];
    logic [3:0]    valid_q;
    logic [1:0]    ptr_q;
    logic [7:0]    cnt_q;
    logic [1:0]    tgt;
    logic          accept;

    // NOTE: every output of a combinational block is given a value on every
    // path, so no latch is inferred.
    always_comb begin
        tgt = bus.in_sel;
        if (bus.rr_en) begin
            tgt = ptr_q;
        end
    end

    // A full channel that is being drained this cycle can still accept; the
    // rst_n term keeps the producer from seeing ready while held in reset.
    assign bus.in_ready = rst_n & (~valid_q[tgt] | bus.out_ready[tgt]);
    assign accept       = bus.in_valid & bus.in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the four data registers are reset too, because out_data
            // must read 0 after reset; this is a tiny flop array, not a RAM.
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (accept && (tgt == 2'(n))) begin
                    // Load wins over drain: replaces the old word without a bubble.
                    data_q[n]  <= bus.in_data;
                    valid_q[n] <= 1'b1;
                end else if (bus.out_ready[n]) begin
                    valid_q[n] <= 1'b0;
                end
            end
            if (accept) begin
                cnt_q <= cnt_q + 8'd1;
                if (bus.rr_en) begin
                    ptr_q <= ptr_q + 2'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign bus.out_data[g*DW +: DW] = data_q[g];
    end

    assign bus.out_valid = valid_q;
    assign bus.rr_ptr    = ptr_q;
    assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_stream_demux4.sv
// tb_stream_demux4: self-checking bench for stream_demux4. A behavioural model
// (per-channel slot array, integer pointer and counter) is advanced once per
// clock from the routing rules and compared against the DUT.
module tb_stream_demux4;
    localparam int DW = 4;

    logic clk;
    logic rst_n;

    stream_demux4_if #(.DW(DW)) bus ();

    stream_demux4 #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_data [4];
    bit            m_valid [4];
    int            m_ptr;
    int            m_cnt;
    bit            exp_rdy;
    logic          obs_rdy;
    bit            last_acc;

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_data[n]  = '0;
            m_valid[n] = 1'b0;
        end
        m_ptr = 0;
        m_cnt = 0;
    endfunction

    function automatic logic [3:0] m_valid_vec();
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = m_valid[n];
        return v;
    endfunction

    function automatic logic [4*DW-1:0] m_data_vec();
        logic [4*DW-1:0] d;
        for (int n = 0; n < 4; n++) d[n*DW +: DW] = m_data[n];
        return d;
    endfunction

    // One clock: drive inputs at the falling edge, sample in_ready before the
    // rising edge, advance the model at the rising edge, leave time 1 unit later.
    task automatic cycle(input logic [DW-1:0] d, input logic [1:0] s, input logic v,
                         input logic rr, input logic [3:0] rdy);
        int t;
        bit acc;
        @(negedge clk);
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.in_valid  = v;
        bus.rr_en     = rr;
        bus.out_ready = rdy;
        #1;
        t       = rr ? m_ptr : int'(s);
        exp_rdy = !m_valid[t] || rdy[t];
        obs_rdy = bus.in_ready;
        acc     = v && exp_rdy;
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            if (acc && t == n) begin
                m_data[n]  = d;
                m_valid[n] = 1'b1;
            end else if (m_valid[n] && rdy[n]) begin
                m_valid[n] = 1'b0;
            end
        end
        if (acc) begin
            m_cnt = (m_cnt + 1) % 256;
            if (rr) m_ptr = (m_ptr + 1) % 4;
        end
        last_acc = acc;
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_data   = 4'h9;
        bus.in_sel    = 2'd1;
        bus.in_valid  = 1'b1;
        bus.rr_en     = 1'b0;
        bus.out_ready = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data !== '0) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data);
        end
        n_checks++;
        if (bus.rr_ptr !== 2'd0 || bus.xfer_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_status: got ptr %0d cnt %0d expected 0 0", bus.rr_ptr, bus.xfer_cnt);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
    endtask

    task automatic test_fixed_select();
        logic [DW-1:0] words [4];
        words[0] = 4'h4; words[1] = 4'h8; words[2] = 4'hC; words[3] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cycle(words[i], 2'(i), 1'b1, 1'b0, 4'b1111);
            n_checks++;
            if (obs_rdy !== 1'b1) begin
                n_fail++; $display("FAIL fixed_in_ready[%0d]: got %b expected 1", i, obs_rdy);
            end
            n_checks++;
            if (bus.out_valid !== 4'(1 << i) || bus.out_data[i*DW +: DW] !== words[i]) begin
                n_fail++; $display("FAIL fixed_route[%0d]: got valid %b data %h expected valid %b data %h",
                                   i, bus.out_valid, bus.out_data[i*DW +: DW], 4'(1 << i), words[i]);
            end
        end
        n_checks++;
        if (bus.xfer_cnt !== 8'd4) begin
            n_fail++; $display("FAIL fixed_xfer_cnt: got %0d expected 4", bus.xfer_cnt);
        end
        cycle(4'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_backpressure();
        cycle(4'hC, 2'd2, 1'b1, 1'b0, 4'b1011);
        cycle(4'h5, 2'd2, 1'b1, 1'b0, 4'b1011);
        n_checks++;
        if (obs_rdy !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready_stalled: got %b expected 0", obs_rdy);
        end
        n_checks++;
        if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*DW +: DW] !== 4'hC) begin
            n_fail++; $display("FAIL bp_hold: got valid %b data %h expected 1 c",
                               bus.out_valid[2], bus.out_data[2*DW +: DW]);
        end
        cycle(4'h5, 2'd2, 1'b1, 1'b0, 4'b1111);
        n_checks++;
        if (obs_rdy !== 1'b1) begin
            n_fail++; $display("FAIL bp_in_ready_drain: got %b expected 1", obs_rdy);
        end
        n_checks++;
        if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*DW +: DW] !== 4'h5) begin
            n_fail++; $display("FAIL bp_replace: got valid %b data %h expected 1 5",
                               bus.out_valid[2], bus.out_data[2*DW +: DW]);
        end
        cycle(4'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_independence();
        cycle(4'h8, 2'd1, 1'b1, 1'b0, 4'b0000);
        cycle(4'h4, 2'd0, 1'b1, 1'b0, 4'b0000);
        cycle(4'hF, 2'd3, 1'b1, 1'b0, 4'b0000);
        n_checks++;
        if (bus.out_valid !== 4'b1011) begin
            n_fail++; $display("FAIL indep_valid: got %b expected 1011", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data !== m_data_vec()) begin
            n_fail++; $display("FAIL indep_data: got %h expected %h", bus.out_data, m_data_vec());
        end
        cycle(4'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL indep_drain_all: got %b expected 0000", bus.out_valid);
        end
    endtask

    task automatic test_round_robin();
        int start_ptr;
        start_ptr = m_ptr;
        for (int i = 0; i < 6; i++) begin
            cycle(4'(i + 1), 2'($urandom_range(0, 3)), 1'b1, 1'b1, 4'b1111);
            n_checks++;
            if (bus.out_valid !== 4'(1 << ((start_ptr + i) % 4)) ||
                bus.out_data[((start_ptr + i) % 4)*DW +: DW] !== 4'(i + 1)) begin
                n_fail++; $display("FAIL rr_route[%0d]: got valid %b data %h expected channel %0d data %h",
                                   i, bus.out_valid, bus.out_data, (start_ptr + i) % 4, 4'(i + 1));
            end
        end
        n_checks++;
        if (bus.rr_ptr !== 2'((start_ptr + 6) % 4)) begin
            n_fail++; $display("FAIL rr_ptr_end: got %0d expected %0d", bus.rr_ptr, (start_ptr + 6) % 4);
        end
        cycle(4'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 4'($urandom));
            n_checks++;
            if (obs_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, obs_rdy, exp_rdy);
            end
            n_checks++;
            if (bus.out_valid !== m_valid_vec() || bus.out_data !== m_data_vec()) begin
                n_fail++; $display("FAIL rand_out[%0d]: got valid %b data %h expected valid %b data %h",
                                   i, bus.out_valid, bus.out_data, m_valid_vec(), m_data_vec());
            end
            n_checks++;
            if (bus.rr_ptr !== 2'(m_ptr) || bus.xfer_cnt !== 8'(m_cnt)) begin
                n_fail++; $display("FAIL rand_status[%0d]: got ptr %0d cnt %0d expected %0d %0d",
                                   i, bus.rr_ptr, bus.xfer_cnt, m_ptr, m_cnt);
            end
        end
        cycle(4'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_counter_wrap();
        int need;
        need = (m_cnt == 0) ? 256 : 256 - m_cnt;
        for (int i = 0; i < need; i++) begin
            cycle(4'($urandom), 2'($urandom), 1'b1, 1'b0, 4'b1111);
        end
        n_checks++;
        if (bus.xfer_cnt !== 8'd0 || m_cnt != 0) begin
            n_fail++; $display("FAIL cnt_wrap: got %0d expected 0", bus.xfer_cnt);
        end
        cycle(4'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
        cycle(4'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_reset_midop();
        cycle(4'hA, 2'd0, 1'b1, 1'b0, 4'b0000);
        cycle(4'h3, 2'd3, 1'b1, 1'b0, 4'b0000);
        cycle(4'h7, 2'd1, 1'b1, 1'b1, 4'b0000);
        n_checks++;
        if (bus.out_valid !== m_valid_vec() || bus.rr_ptr !== 2'(m_ptr)) begin
            n_fail++; $display("FAIL midop_pre: got valid %b ptr %0d expected %b %0d",
                               bus.out_valid, bus.rr_ptr, m_valid_vec(), m_ptr);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        rst_n        = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bus.out_valid !== 4'b0000 || bus.rr_ptr !== 2'd0 || bus.xfer_cnt !== 8'd0) begin
            n_fail++; $display("FAIL midop_clear: got valid %b ptr %0d cnt %0d expected 0000 0 0",
                               bus.out_valid, bus.rr_ptr, bus.xfer_cnt);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midop_in_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        cycle(4'h6, 2'd2, 1'b1, 1'b0, 4'b1111);
        n_checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_data[2*DW +: DW] !== 4'h6 || bus.xfer_cnt !== 8'd1) begin
            n_fail++; $display("FAIL midop_resume: got valid %b data %h cnt %0d expected 0100 6 1",
                               bus.out_valid, bus.out_data[2*DW +: DW], bus.xfer_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_backpressure();
        test_independence();
        test_round_robin();
        test_random();
        test_counter_wrap();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
